ice40_reset_seq: RTL and testbench

//   Parametrised reset sequencer, successor to the single-output power-on reset counter.

---
 rtl/ice40_reset_seq.sv | 190 +++++++++++++++++++
 tb/tb_ice40_reset_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ice40_reset_seq.sv
// ice40_reset_seq
//   Reset sequencer for the SoM top level. It sits between the PLL and every
//   clock-domain-local reset tree. Four reset sources are merged: soft reset,
//   the debounced external pin, loss of PLL lock and an optional watchdog.
//   All domains are held in reset until the sources have been quiet for
//   HOLD_CYCLES. The NUM_CH active-low resets are then released one at a
//   time, STAGE_CYCLES apart, with bit 0 released first.
//
//   Optional feature macro: RSTSEQ_WDOG_EN adds the watchdog. This adds the
//   WDOG_CYCLES parameter and the wdog_kick and wdog_fired ports.
//
// Ports
//   clk         in   1       single system clock
//   reset       in   1       synchronous, active-high soft reset request
//   ext_rst_n   in   1       asynchronous external reset pin, active low
//   pll_lock    in   1       PLL lock indicator, level
//   wdog_kick   in   1       watchdog restart pulse       (RSTSEQ_WDOG_EN)
//   wdog_fired  out  1       1-cycle pulse on timeout     (RSTSEQ_WDOG_EN)
//   resetn      out  NUM_CH  sequenced resets, active low, bit 0 first
//   done        out  1       all channels released (state RUN)
//   cause       out  4       cause of last HOLD entry {wdog, lock, ext, soft}
module ice40_reset_seq #(
   parameter int unsigned NUM_CH       = 3,
   parameter int unsigned HOLD_CYCLES  = 255,
   parameter int unsigned STAGE_CYCLES = 16,
   parameter int unsigned FILT_CYCLES  = 4
`ifdef RSTSEQ_WDOG_EN
   ,
   parameter int unsigned WDOG_CYCLES  = 1024
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ext_rst_n,
   input  logic              pll_lock,
`ifdef RSTSEQ_WDOG_EN
   input  logic              wdog_kick,
   output logic              wdog_fired,
`endif
   output logic [NUM_CH-1:0] resetn,
   output logic              done,
   output logic [3:0]        cause
);

   localparam int unsigned HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
   localparam int unsigned SW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
   localparam int unsigned IW = (NUM_CH       > 1) ? $clog2(NUM_CH)       : 1;
   localparam int unsigned FW = $clog2(FILT_CYCLES + 1);

   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
   localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_CYCLES - 1);
   localparam logic [IW-1:0] CH_LAST    = IW'(NUM_CH - 1);
   localparam logic [FW-1:0] FILT_MAX   = FW'(FILT_CYCLES);

   // HOLD encodes as zero so that the iCE40 power-up state matches reset.
   typedef enum logic [1:0] {
      HOLD = 2'd0,
      SEQ  = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t            state, state_d;
   logic [HW-1:0]     hold_cnt, hold_d;
   logic [SW-1:0]     stage_cnt, stage_d;
   logic [IW-1:0]     idx, idx_d;
   logic [NUM_CH-1:0] resetn_d;
   logic              done_d;
   logic [3:0]        cause_d;

   logic              ext_s1, ext_s2;
   logic [FW-1:0]     ext_run;
   logic              ext_req;
   logic              wdog_to;
   logic [3:0]        smp;
   logic              src;

   // External pin: two-flop synchroniser, then a saturating count of
   // consecutive low samples. Any high sample discards the run.
   always_ff @(posedge clk) begin
      ext_s1 <= ext_rst_n;
      ext_s2 <= ext_s1;
      if (ext_s2)
         ext_run <= '0;
      else if (ext_run != FILT_MAX)
         ext_run <= ext_run + FW'(1);
   end

   assign ext_req = (ext_run >= FILT_MAX);

`ifdef RSTSEQ_WDOG_EN
   localparam int unsigned WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

   logic [WW-1:0] wdog_cnt;

   // A kick on the terminal cycle suppresses the timeout.
   assign wdog_to = (state == RUN) && (wdog_cnt == WDOG_LAST) && !wdog_kick;

   always_ff @(posedge clk) begin
      if (reset || (state != RUN) || wdog_kick || wdog_to)
         wdog_cnt <= '0;
      else
         wdog_cnt <= wdog_cnt + WW'(1);
      wdog_fired <= wdog_to;
   end
`else
   assign wdog_to = 1'b0;
`endif

   assign smp = {wdog_to, ~pll_lock, ext_req, reset};
   assign src = |smp;

   always_comb begin
      state_d  = state;
      hold_d   = hold_cnt;
      stage_d  = stage_cnt;
      idx_d    = idx;
      resetn_d = resetn;
      done_d   = done;
      cause_d  = cause;

      if (src) begin
         // Any active source has priority over a terminal count.
         state_d  = HOLD;
         hold_d   = '0;
         stage_d  = '0;
         idx_d    = '0;
         resetn_d = '0;
         done_d   = 1'b0;
         // A fresh HOLD entry records only the sources active now.
         // While already holding, new sources are added to the cause.
         if (state == HOLD)
            cause_d = cause | smp;
         else
            cause_d = smp;
      end else begin
         case (state)
            HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state_d = SEQ;
                  hold_d  = '0;
                  stage_d = '0;
                  idx_d   = '0;
               end else begin
                  hold_d  = hold_cnt + HW'(1);
               end
            end
            SEQ: begin
               if (stage_cnt == STAGE_LAST) begin
                  stage_d = '0;
                  for (int unsigned i = 0; i < NUM_CH; i++) begin
                     if (idx == IW'(i))
                        resetn_d[i] = 1'b1;
                  end
                  if (idx == CH_LAST) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end else begin
                     idx_d   = idx + IW'(1);
                  end
               end else begin
                  stage_d = stage_cnt + SW'(1);
               end
            end
            RUN: ;
            default: state_d = HOLD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= HOLD;
         hold_cnt  <= '0;
         stage_cnt <= '0;
         idx       <= '0;
         resetn    <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_d;
         hold_cnt  <= hold_d;
         stage_cnt <= stage_d;
         idx       <= idx_d;
         resetn    <= resetn_d;
         done      <= done_d;
      end
      cause <= cause_d;
   end

endmodule

// File: tb/tb_ice40_reset_seq.sv
// tb_ice40_reset_seq
//   Self-checking bench for ice40_reset_seq using NUM_CH=3, HOLD=8, STAGE=4,
//   FILT=4 and WDOG=32. Each scenario task pushes the expected
//   {resetn, done, cause, wdog_fired} values for specific clock edges onto a
//   scoreboard queue. The task then drives its stimulus schedule and pops
//   and compares the entries as those edges are reached.
module tb_ice40_reset_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       ext_rst_n;
   logic       pll_lock;
   logic [2:0] resetn;
   logic       done;
   logic [3:0] cause;
   logic       wdog_fired;
`ifdef RSTSEQ_WDOG_EN
   logic       wdog_kick;
`endif

   always #5 clk = ~clk;

   ice40_reset_seq #(
      .NUM_CH       (3),
      .HOLD_CYCLES  (8),
      .STAGE_CYCLES (4),
      .FILT_CYCLES  (4)
`ifdef RSTSEQ_WDOG_EN
      ,
      .WDOG_CYCLES  (32)
`endif
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ext_rst_n  (ext_rst_n),
      .pll_lock   (pll_lock),
`ifdef RSTSEQ_WDOG_EN
      .wdog_kick  (wdog_kick),
      .wdog_fired (wdog_fired),
`endif
      .resetn     (resetn),
      .done       (done),
      .cause      (cause)
   );

`ifndef RSTSEQ_WDOG_EN
   assign wdog_fired = 1'b0;
`endif

   // Observation vector: {resetn[2:0], done, cause[3:0], wdog_fired}
   logic [8:0] obs;
   assign obs = {resetn, done, cause, wdog_fired};

   localparam logic [8:0] M_RN  = 9'b111_0_0000_0;
   localparam logic [8:0] M_DN  = 9'b000_1_0000_0;
   localparam logic [8:0] M_CS  = 9'b000_0_1111_0;
   localparam logic [8:0] M_ALL = 9'b111_1_1111_1;

   typedef struct {
      int unsigned at;
      string       name;
      logic [8:0]  val;
      logic [8:0]  mask;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc    = 0;
   int unsigned tests  = 0;
   int unsigned failed = 0;

   function automatic logic [8:0] pk(logic [2:0] rn, logic dn, logic [3:0] cs, logic fd);
      return {rn, dn, cs, fd};
   endfunction

   function automatic void push_exp(int unsigned at, string name, logic [8:0] val, logic [8:0] mask);
      exp_t e;
      e.at   = at;
      e.name = name;
      e.val  = val;
      e.mask = mask;
      sb.push_back(e);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Starts in RUN. Soft reset for 3 cycles, then the full release sequence.
   task automatic test_reset();
      int unsigned t0;
      exp_t        e;
      t0 = cyc;
      push_exp(t0 + 1,  "reset_state",   pk(3'b000, 1'b0, 4'b0001, 1'b0), M_ALL);
      push_exp(t0 + 14, "reset_rn0_pre", pk(3'b000, 1'b0, 4'b0000, 1'b0), M_RN);
      push_exp(t0 + 15, "reset_rn0",     pk(3'b001, 1'b0, 4'b0000, 1'b0), M_RN);
      push_exp(t0 + 18, "reset_rn1_pre", pk(3'b001, 1'b0, 4'b0000, 1'b0), M_RN);
      push_exp(t0 + 19, "reset_rn1",     pk(3'b011, 1'b0, 4'b0000, 1'b0), M_RN);
      push_exp(t0 + 22, "reset_rn2_pre", pk(3'b011, 1'b0, 4'b0000, 1'b0), M_RN | M_DN);
      push_exp(t0 + 23, "reset_done",    pk(3'b111, 1'b1, 4'b0001, 1'b0), M_ALL);
      reset = 1'b1;
      for (int unsigned n = 1; n <= 24; n++) begin
         tick();
         if (n == 3) reset = 1'b0;
         while (sb.size() != 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (((obs ^ e.val) & e.mask) !== '0) begin
               failed++;
               $display("FAIL %s @%0d: got %b, expected %b (mask %b)", e.name, cyc, obs, e.val, e.mask);
            end
         end
      end
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL reset_unchecked: %0d entries left, expected 0", sb.size());
         sb.delete();
      end
   endtask

   // A 2-cycle lock loss at HOLD count 5 restarts the quiet period.
   task automatic test_lock_restart();
      int unsigned t0;
      exp_t        e;
      t0 = cyc;
      push_exp(t0 + 1,  "lockhold_enter",  pk(3'b000, 1'b0, 4'b0001, 1'b0), M_ALL);
      push_exp(t0 + 7,  "lockhold_cause",  pk(3'b000, 1'b0, 4'b0101, 1'b0), M_RN | M_CS);
      push_exp(t0 + 13, "lockhold_norel",  pk(3'b000, 1'b0, 4'b0000, 1'b0), M_RN);
      push_exp(t0 + 19, "lockhold_pre",    pk(3'b000, 1'b0, 4'b0000, 1'b0), M_RN);
      push_exp(t0 + 20, "lockhold_rn0",    pk(3'b001, 1'b0, 4'b0000, 1'b0), M_RN);
      push_exp(t0 + 28, "lockhold_done",   pk(3'b111, 1'b1, 4'b0101, 1'b0), M_ALL);
      reset = 1'b1;
      for (int unsigned n = 1; n <= 29; n++) begin
         tick();
         if (n == 1) reset    = 1'b0;
         if (n == 6) pll_lock = 1'b0;
         if (n == 8) pll_lock = 1'b1;
         while (sb.size() != 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (((obs ^ e.val) & e.mask) !== '0) begin
               failed++;
               $display("FAIL %s @%0d: got %b, expected %b (mask %b)", e.name, cyc, obs, e.val, e.mask);
            end
         end
      end
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL lockhold_unchecked: %0d entries left, expected 0", sb.size());
         sb.delete();
      end
   endtask

   // Starts in RUN. A 3-cycle pin glitch is ignored. A 6-cycle pin low resets.
   task automatic test_ext_filter();
      int unsigned t0;
      exp_t        e;
      t0 = cyc;
      push_exp(t0 + 4,  "ext_glitch_a",  pk(3'b111, 1'b1, 4'b0101, 1'b0), M_ALL);
      push_exp(t0 + 8,  "ext_glitch_b",  pk(3'b111, 1'b1, 4'b0101, 1'b0), M_ALL);
      push_exp(t0 + 16, "ext_pre",       pk(3'b111, 1'b1, 4'b0101, 1'b0), M_ALL);
      push_exp(t0 + 17, "ext_hold",      pk(3'b000, 1'b0, 4'b0010, 1'b0), M_ALL);
      push_exp(t0 + 30, "ext_rn0_pre",   pk(3'b000, 1'b0, 4'b0000, 1'b0), M_RN);
      push_exp(t0 + 31, "ext_rn0",       pk(3'b001, 1'b0, 4'b0000, 1'b0), M_RN);
      push_exp(t0 + 39, "ext_done",      pk(3'b111, 1'b1, 4'b0010, 1'b0), M_ALL);
      ext_rst_n = 1'b0;
      for (int unsigned n = 1; n <= 40; n++) begin
         tick();
         if (n == 3)  ext_rst_n = 1'b1;
         if (n == 10) ext_rst_n = 1'b0;
         if (n == 16) ext_rst_n = 1'b1;
         while (sb.size() != 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (((obs ^ e.val) & e.mask) !== '0) begin
               failed++;
               $display("FAIL %s @%0d: got %b, expected %b (mask %b)", e.name, cyc, obs, e.val, e.mask);
            end
         end
      end
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL ext_unchecked: %0d entries left, expected 0", sb.size());
         sb.delete();
      end
   endtask

   // Lock drops while resetn=001 in SEQ, then the full sequence repeats.
   task automatic test_lock_in_seq();
      int unsigned t0;
      exp_t        e;
      t0 = cyc;
      push_exp(t0 + 1,  "lockseq_enter",  pk(3'b000, 1'b0, 4'b0001, 1'b0), M_ALL);
      push_exp(t0 + 13, "lockseq_rn0",    pk(3'b001, 1'b0, 4'b0000, 1'b0), M_RN | M_DN);
      push_exp(t0 + 14, "lockseq_rn0_b",  pk(3'b001, 1'b0, 4'b0000, 1'b0), M_RN | M_DN);
      push_exp(t0 + 15, "lockseq_drop",   pk(3'b000, 1'b0, 4'b0100, 1'b0), M_ALL);
      push_exp(t0 + 27, "lockseq_pre",    pk(3'b000, 1'b0, 4'b0000, 1'b0), M_RN);
      push_exp(t0 + 28, "lockseq_rn0_2",  pk(3'b001, 1'b0, 4'b0000, 1'b0), M_RN);
      push_exp(t0 + 36, "lockseq_done",   pk(3'b111, 1'b1, 4'b0100, 1'b0), M_ALL);
      reset = 1'b1;
      for (int unsigned n = 1; n <= 37; n++) begin
         tick();
         if (n == 1)  reset    = 1'b0;
         if (n == 14) pll_lock = 1'b0;
         if (n == 16) pll_lock = 1'b1;
         while (sb.size() != 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (((obs ^ e.val) & e.mask) !== '0) begin
               failed++;
               $display("FAIL %s @%0d: got %b, expected %b (mask %b)", e.name, cyc, obs, e.val, e.mask);
            end
         end
      end
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL lockseq_unchecked: %0d entries left, expected 0", sb.size());
         sb.delete();
      end
   endtask

   // Soft reset coincides with the terminal count of the second stage.
   task automatic test_reset_on_terminal();
      int unsigned t0;
      exp_t        e;
      t0 = cyc;
      push_exp(t0 + 13, "term_rn0",      pk(3'b001, 1'b0, 4'b0000, 1'b0), M_RN);
      push_exp(t0 + 16, "term_pre",      pk(3'b001, 1'b0, 4'b0000, 1'b0), M_RN | M_DN);
      push_exp(t0 + 17, "term_src_wins", pk(3'b000, 1'b0, 4'b0001, 1'b0), M_ALL);
      push_exp(t0 + 18, "term_held",     pk(3'b000, 1'b0, 4'b0001, 1'b0), M_ALL);
      push_exp(t0 + 29, "term_rn0_2",    pk(3'b001, 1'b0, 4'b0000, 1'b0), M_RN);
      push_exp(t0 + 37, "term_done",     pk(3'b111, 1'b1, 4'b0001, 1'b0), M_ALL);
      reset = 1'b1;
      for (int unsigned n = 1; n <= 38; n++) begin
         tick();
         if (n == 1)  reset = 1'b0;
         if (n == 16) reset = 1'b1;
         if (n == 17) reset = 1'b0;
         while (sb.size() != 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (((obs ^ e.val) & e.mask) !== '0) begin
               failed++;
               $display("FAIL %s @%0d: got %b, expected %b (mask %b)", e.name, cyc, obs, e.val, e.mask);
            end
         end
      end
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL term_unchecked: %0d entries left, expected 0", sb.size());
         sb.delete();
      end
   endtask

`ifdef RSTSEQ_WDOG_EN
   // Kicks every 20 cycles keep RUN alive. Once kicks stop, the watchdog
   // fires 32 cycles later, and again 32 cycles after the next done.
   task automatic test_wdog();
      int unsigned t0;
      exp_t        e;
      t0 = cyc;
      push_exp(t0 + 21,  "wdog_done",     pk(3'b111, 1'b1, 4'b0001, 1'b0), M_ALL);
      push_exp(t0 + 50,  "wdog_kick_a",   pk(3'b111, 1'b1, 4'b0001, 1'b0), M_ALL);
      push_exp(t0 + 70,  "wdog_kick_b",   pk(3'b111, 1'b1, 4'b0001, 1'b0), M_ALL);
      push_exp(t0 + 100, "wdog_kick_c",   pk(3'b111, 1'b1, 4'b0001, 1'b0), M_ALL);
      push_exp(t0 + 112, "wdog_pre",      pk(3'b111, 1'b1, 4'b0001, 1'b0), M_ALL);
      push_exp(t0 + 113, "wdog_fire",     pk(3'b000, 1'b0, 4'b1000, 1'b1), M_ALL);
      push_exp(t0 + 114, "wdog_pulse",    pk(3'b000, 1'b0, 4'b1000, 1'b0), M_ALL);
      push_exp(t0 + 133, "wdog_done_2",   pk(3'b111, 1'b1, 4'b1000, 1'b0), M_ALL);
      push_exp(t0 + 164, "wdog_pre_2",    pk(3'b111, 1'b1, 4'b1000, 1'b0), M_ALL);
      push_exp(t0 + 165, "wdog_fire_2",   pk(3'b000, 1'b0, 4'b1000, 1'b1), M_ALL);
      reset     = 1'b1;
      wdog_kick = 1'b0;
      for (int unsigned n = 1; n <= 166; n++) begin
         tick();
         if (n == 1) reset = 1'b0;
         wdog_kick = (n == 40 || n == 60 || n == 80);
         while (sb.size() != 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (((obs ^ e.val) & e.mask) !== '0) begin
               failed++;
               $display("FAIL %s @%0d: got %b, expected %b (mask %b)", e.name, cyc, obs, e.val, e.mask);
            end
         end
      end
      wdog_kick = 1'b0;
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL wdog_unchecked: %0d entries left, expected 0", sb.size());
         sb.delete();
      end
   endtask
`endif

   initial begin
      reset     = 1'b1;
      ext_rst_n = 1'b1;
      pll_lock  = 1'b1;
`ifdef RSTSEQ_WDOG_EN
      wdog_kick = 1'b0;
`endif
      // Bring-up: settle the pin synchroniser and reach RUN once.
      repeat (4) tick();
      reset = 1'b0;
      repeat (24) tick();

      test_reset();
      test_lock_restart();
      test_ext_filter();
      test_lock_in_seq();
      test_reset_on_terminal();
`ifdef RSTSEQ_WDOG_EN
      test_wdog();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
